// File: rtl/serial_terminal_receiver_if.sv
// Consumer-side byte stream of the terminal serial receiver.
// The receiver drives the FIFO head, occupancy and one-cycle status pulses;
// the consumer drives RX_READY. RX_PARITY_ERR exists only when
// SERIAL_RX_PARITY_EN is defined.
//
// Handshake: RX_VALID is high whenever the FIFO holds a byte and RX_DATA is
// the head byte while RX_VALID is high. A byte is transferred (popped) on
// every rising CLK edge where RX_VALID && RX_READY; RX_READY while RX_VALID
// is low has no effect, and RX_VALID/RX_DATA never depend on RX_READY.
interface serial_terminal_receiver_if #(
    parameter int CNT_W = 3
);
    logic [7:0]       RX_DATA;
    logic             RX_VALID;
    logic             RX_READY;
    logic [CNT_W-1:0] RX_COUNT;
    logic             RX_FRAME_ERR;
    logic             RX_OVERRUN;
`ifdef SERIAL_RX_PARITY_EN
    logic             RX_PARITY_ERR;
`endif

`ifdef SERIAL_RX_PARITY_EN
    modport master (
        output RX_DATA, RX_VALID, RX_COUNT, RX_FRAME_ERR, RX_OVERRUN, RX_PARITY_ERR,
        input  RX_READY
    );
    modport slave (
        input  RX_DATA, RX_VALID, RX_COUNT, RX_FRAME_ERR, RX_OVERRUN, RX_PARITY_ERR,
        output RX_READY
    );
`else
    modport master (
        output RX_DATA, RX_VALID, RX_COUNT, RX_FRAME_ERR, RX_OVERRUN,
        input  RX_READY
    );
    modport slave (
        input  RX_DATA, RX_VALID, RX_COUNT, RX_FRAME_ERR, RX_OVERRUN,
        output RX_READY
    );
`endif
endinterface

// File: rtl/serial_terminal_receiver.sv
// serial_terminal_receiver: UART receiver for the terminal serial stream.
// Frame is 8N1 LSB first (8E1 when SERIAL_RX_PARITY_EN is defined).
// The line is synchronised by two flops, bits are sampled mid-bit with a
// down-counting bit timer, and good bytes are buffered in a small
// first-word-fall-through FIFO read through serial_terminal_receiver_if.
// DBG_STATE exposes the receive FSM state encoding:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY (parity build only), 4 STOP, 5 BREAK.
module serial_terminal_receiver #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN_SERIAL_RX,
    serial_terminal_receiver_if.master rx_if,
    output logic [2:0]                 DBG_STATE
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Half a bit from the start edge lands the samples near mid-bit;
    // afterwards the timer reloads so each sample is one bit period apart.
    localparam logic [TW-1:0] HALF_BIT   = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;
`endif

    // ------------------------------------------------------------------
    // Line synchroniser and edge history
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic rx_prev;
    logic rx_s;

    assign rx_s = sync2;

    // Two-flop synchroniser plus one history flop for start-edge detection;
    // all preset to the idle-high level so reset never looks like a start.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= IN_SERIAL_RX;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t       state;
    rx_state_t       state_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;
    logic [2:0]      idx;
    logic [2:0]      idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic            tick;
    logic            push;
    logic            frame_err_c;
`ifdef SERIAL_RX_PARITY_EN
    logic            parity_err_c;
`endif

    assign tick = (timer == '0);

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic: sample on timer expiry, push good bytes, flag errors.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        idx_n       = idx;
        shreg_n     = shreg;
        push        = 1'b0;
        frame_err_c = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_c = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    timer_n = HALF_BIT;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        idx_n   = 3'd0;
                        timer_n = FULL_BIT_M1;
                        state_n = S_DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_n = S_IDLE;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n[idx] = rx_s;
                    timer_n      = FULL_BIT_M1;
                    if (idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    // Even parity: the parity bit equals the XOR of the data.
                    parity_err_c = (rx_s != (^shreg));
                    timer_n      = FULL_BIT_M1;
                    state_n      = S_STOP;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_n     = S_BREAK;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a long low line
                // reports a single framing error.
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign DBG_STATE = state;

    // ------------------------------------------------------------------
    // Byte FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             overrun_c;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign pop       = rx_if.RX_READY && !empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign wr_en     = push && (!full || pop);
    assign overrun_c = push && full && !pop;

    // Storage array; written only on an accepted push.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    // Read/write pointers with one extra bit so full and empty differ.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status pulses
    // ------------------------------------------------------------------
    logic frame_err_q;
    logic overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    logic parity_err_q;
`endif

    // One-cycle registered error pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= frame_err_c;
            overrun_q   <= overrun_c;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= parity_err_c;
`endif
        end
    end

    assign rx_if.RX_DATA      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign rx_if.RX_VALID     = !empty;
    assign rx_if.RX_COUNT     = count;
    assign rx_if.RX_FRAME_ERR = frame_err_q;
    assign rx_if.RX_OVERRUN   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign rx_if.RX_PARITY_ERR = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_terminal_receiver.sv
// Directed bench for serial_terminal_receiver with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// Define SERIAL_RX_PARITY_EN to build and exercise the 8E1 variant.
module tb_serial_terminal_receiver;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic       CLK;
    logic       RESET;
    logic       IN_SERIAL_RX;
    logic [2:0] DBG_STATE;

    serial_terminal_receiver_if #(.CNT_W(CW)) rx_if ();

    serial_terminal_receiver #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IN_SERIAL_RX(IN_SERIAL_RX),
        .rx_if       (rx_if),
        .DBG_STATE   (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Pulse counters, sampled mid-cycle.
    int fe_cnt  = 0;
    int ovr_cnt = 0;
    int pe_cnt  = 0;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (rx_if.RX_FRAME_ERR) fe_cnt++;
            if (rx_if.RX_OVERRUN)   ovr_cnt++;
`ifdef SERIAL_RX_PARITY_EN
            if (rx_if.RX_PARITY_ERR) pe_cnt++;
`endif
        end
    end

    // Watchdog: every wait below is a fixed cycle count, this only guards hangs.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        IN_SERIAL_RX = b;
        step(n);
    endtask

    // Sends one frame. stop_len < CPB ends early inside the stop bit;
    // pop_at_stop raises RX_READY only for the last stop-bit cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_len, input logic pop_at_stop,
                              input logic par_flip);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, CPB);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_val, stop_len - 1);
        if (pop_at_stop) rx_if.RX_READY = 1'b1;
        drive_bit(stop_val, 1);
        rx_if.RX_READY = 1'b0;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        d = rx_if.RX_DATA;
        rx_if.RX_READY = 1'b1;
        step(1);
        rx_if.RX_READY = 1'b0;
    endtask

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_if.RX_VALID);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd0) $display("FAIL reset_count: got %0d want 0", rx_if.RX_COUNT);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_DATA !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_if.RX_DATA);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_FRAME_ERR !== 1'b0 || rx_if.RX_OVERRUN !== 1'b0)
            $display("FAIL reset_errs: got fe=%b ovr=%b want 0 0", rx_if.RX_FRAME_ERR, rx_if.RX_OVERRUN);
        else pass_cnt++;
        total_cnt++;
        if (DBG_STATE !== 3'd0) $display("FAIL reset_state: got %0d want 0", DBG_STATE);
        else pass_cnt++;
        // Pop while empty must be ignored.
        pop_byte(d);
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd0) $display("FAIL empty_pop_count: got %0d want 0", rx_if.RX_COUNT);
        else pass_cnt++;
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        send_frame(8'h41, 1'b1, CPB - 1, 1'b0, 1'b0);
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b0) $display("FAIL early_valid: got %b want 0", rx_if.RX_VALID);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b1) $display("FAIL single_valid: got %b want 1", rx_if.RX_VALID);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_DATA !== 8'h41) $display("FAIL single_data: got %h want 41", rx_if.RX_DATA);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd1) $display("FAIL single_count: got %0d want 1", rx_if.RX_COUNT);
        else pass_cnt++;
        pop_byte(d);
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b0) $display("FAIL single_drain: got %b want 0", rx_if.RX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [5];
        logic [7:0] d;
        logic [7:0] e;
        int ovr0;
        bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h00;
        bytes[3] = 8'hFF; bytes[4] = 8'h7E;
        ovr0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(bytes[i], 1'b1, CPB, 1'b0, 1'b0);
            if (i < 4) exp_q.push_back(bytes[i]);
        end
        step(2);
        total_cnt++;
        if (ovr_cnt - ovr0 != 1) $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - ovr0);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd4) $display("FAIL overrun_count: got %0d want 4", rx_if.RX_COUNT);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            pop_byte(d);
            total_cnt++;
            if (d !== e) $display("FAIL overrun_pop%0d: got %h want %h", i, d, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b0) $display("FAIL overrun_drain: got %b want 0", rx_if.RX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, CPB, 1'b0, 1'b0);
        drive_bit(1'b0, 10);
        total_cnt++;
        if (DBG_STATE !== 3'd5) $display("FAIL break_state: got %0d want 5", DBG_STATE);
        else pass_cnt++;
        drive_bit(1'b0, 30);
        drive_bit(1'b1, 12);
        total_cnt++;
        if (fe_cnt - fe0 != 1) $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd0) $display("FAIL frame_err_count: got %0d want 0", rx_if.RX_COUNT);
        else pass_cnt++;
        total_cnt++;
        if (DBG_STATE !== 3'd0) $display("FAIL break_exit: got %0d want 0", DBG_STATE);
        else pass_cnt++;
        send_frame(8'h12, 1'b1, CPB, 1'b0, 1'b0);
        total_cnt++;
        if (rx_if.RX_DATA !== 8'h12 || rx_if.RX_COUNT !== 3'd1)
            $display("FAIL after_break_byte: got %h/%0d want 12/1", rx_if.RX_DATA, rx_if.RX_COUNT);
        else pass_cnt++;
        pop_byte(d);
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        total_cnt++;
        if (rx_if.RX_VALID !== 1'b0 || fe_cnt != fe0)
            $display("FAIL glitch_effect: got valid=%b fe=%0d want 0 0", rx_if.RX_VALID, fe_cnt - fe0);
        else pass_cnt++;
        total_cnt++;
        if (DBG_STATE !== 3'd0) $display("FAIL glitch_state: got %0d want 0", DBG_STATE);
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        logic [7:0] d;
        logic [7:0] e;
        int ovr0;
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, CPB, 1'b0, 1'b0);
            exp_q.push_back(8'(i));
        end
        send_frame(8'h99, 1'b1, CPB, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        step(2);
        total_cnt++;
        if (ovr_cnt != ovr0) $display("FAIL full_pop_overrun: got %0d want 0", ovr_cnt - ovr0);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd4) $display("FAIL full_pop_count: got %0d want 4", rx_if.RX_COUNT);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            pop_byte(d);
            total_cnt++;
            if (d !== e) $display("FAIL full_pop%0d: got %h want %h", i, d, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int fe0;
        send_frame(8'h77, 1'b1, CPB, 1'b0, 1'b0);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, 4);
        IN_SERIAL_RX = 1'b1;
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        total_cnt++;
        if (rx_if.RX_COUNT !== 3'd0 || rx_if.RX_VALID !== 1'b0)
            $display("FAIL midreset_fifo: got %0d/%b want 0/0", rx_if.RX_COUNT, rx_if.RX_VALID);
        else pass_cnt++;
        total_cnt++;
        if (DBG_STATE !== 3'd0) $display("FAIL midreset_state: got %0d want 0", DBG_STATE);
        else pass_cnt++;
        step(12);
        fe0 = fe_cnt;
        send_frame(8'h5A, 1'b1, CPB, 1'b0, 1'b0);
        step(1);
        total_cnt++;
        if (rx_if.RX_DATA !== 8'h5A || rx_if.RX_COUNT !== 3'd1 || fe_cnt != fe0)
            $display("FAIL midreset_byte: got %h/%0d fe=%0d want 5a/1 fe=0",
                     rx_if.RX_DATA, rx_if.RX_COUNT, fe_cnt - fe0);
        else pass_cnt++;
        pop_byte(d);
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        int pe0;
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, CPB, 1'b0, 1'b1);
        step(1);
        total_cnt++;
        if (pe_cnt - pe0 != 1) $display("FAIL parity_pulse: got %0d want 1", pe_cnt - pe0);
        else pass_cnt++;
        total_cnt++;
        if (rx_if.RX_DATA !== 8'h07 || rx_if.RX_COUNT !== 3'd1)
            $display("FAIL parity_byte: got %h/%0d want 07/1", rx_if.RX_DATA, rx_if.RX_COUNT);
        else pass_cnt++;
        pop_byte(d);
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, CPB, 1'b0, 1'b0);
        step(1);
        total_cnt++;
        if (pe_cnt != pe0 || rx_if.RX_DATA !== 8'h03)
            $display("FAIL parity_good: got pe=%0d data=%h want 0 03", pe_cnt - pe0, rx_if.RX_DATA);
        else pass_cnt++;
        pop_byte(d);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        RESET          = 1'b1;
        IN_SERIAL_RX   = 1'b1;
        rx_if.RX_READY = 1'b0;
        step(3);
        RESET = 1'b0;
        test_reset();
        step(4);
        test_single_byte();
        step(4);
        test_overrun();
        step(4);
        test_frame_error();
        step(4);
        test_glitch();
        test_full_pop();
        step(4);
        test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
        step(4);
        test_parity();
`endif
        step(4);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
